// File: rtl/dcro_freq_meter.sv
// ============================================================================
// Module   : dcro_freq_meter
// Brief    : Gated edge counter measuring the frequency of a DCRO output.
//            Define DCRO_FREQ_METER_CONT_EN to add back-to-back measurement
//            via the cont input.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dcro_freq_meter #(
   parameter int CNT_W  = 16,
   parameter int GATE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              ro_in,
`ifdef DCRO_FREQ_METER_CONT_EN
   input  logic              cont,
`endif
   output logic              ro_en,
   output logic              busy,
   output logic              valid,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam logic [GATE_W-1:0] c_SETTLE_LAST = GATE_W'(3);
   localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [GATE_W-1:0]   r_gate, w_gate_nxt;
   logic [GATE_W-1:0]   r_timer, w_timer_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_ovf, w_ovf_nxt;
   logic                r_s1, r_s2, r_s3;
   logic [CNT_W-1:0]    r_count;
   logic                r_overflow;
   logic                w_edge;
   logic                w_cont;

`ifdef DCRO_FREQ_METER_CONT_EN
   assign w_cont = cont;
`else
   assign w_cont = 1'b0;
`endif

   // s1/s2 resolve metastability; s3 is the delayed copy for edge detection
   assign w_edge = r_s2 & ~r_s3;

   always_comb begin
      w_state_nxt = r_state;
      w_gate_nxt  = r_gate;
      w_timer_nxt = r_timer;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_timer_nxt = '0;
            if (start) begin
               w_state_nxt = S_SETTLE;
               w_gate_nxt  = gate_cycles;
            end
         end
         S_SETTLE: begin
            if (r_timer == c_SETTLE_LAST) begin
               w_timer_nxt = '0;
               w_state_nxt = (r_gate == '0) ? S_DONE : S_MEASURE;
            end else begin
               w_timer_nxt = r_timer + GATE_W'(1);
            end
         end
         S_MEASURE: begin
            w_cnt_nxt = r_cnt;
            w_ovf_nxt = r_ovf;
            if (w_edge) begin
               if (r_cnt == c_CNT_MAX) w_ovf_nxt = 1'b1;
               else                    w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            if (r_timer == r_gate - GATE_W'(1)) begin
               w_timer_nxt = '0;
               w_state_nxt = S_DONE;
            end else begin
               w_timer_nxt = r_timer + GATE_W'(1);
            end
         end
         S_DONE: begin
            w_timer_nxt = '0;
            w_state_nxt = w_cont ? S_SETTLE : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_gate     <= '0;
         r_timer    <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gate  <= w_gate_nxt;
         r_timer <= w_timer_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
         r_s1    <= ro_in;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         // result registers load on entry to DONE so they are visible with valid
         if (w_state_nxt == S_DONE) begin
            r_count    <= w_cnt_nxt;
            r_overflow <= w_ovf_nxt;
         end
      end
   end

   assign busy     = (r_state != S_IDLE);
   assign ro_en    = (r_state == S_SETTLE) || (r_state == S_MEASURE);
   assign valid    = (r_state == S_DONE);
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

`default_nettype wire
